// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the uart_tx round-robin arbiter.
// Tag states and TAG_NIBBLE are used only when UART_ARB_TAG_EN is defined.
package uart_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE,
    TAG_LAUNCH,
    TAG_BUSY,
    TAG_DONE
  } arb_state_e;

  localparam logic [3:0] TAG_NIBBLE = 4'hA;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  // First set bit of valid at or above ptr, wrapping within n requesters.
  function automatic pick_t rr_pick(input logic [7:0] valid, input logic [2:0] ptr, input int n);
    pick_t r;
    int    k;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < n && !r.found) begin
        k = (int'(ptr) + i) % n;
        if (valid[k[2:0]]) begin
          r.found = 1'b1;
          r.idx   = k[2:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_picker.sv
// Combinational round-robin priority search over NUM_REQ requesters.
module uart_rr_picker
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [2:0]         ptr,
  output logic               found,
  output logic [2:0]         idx
);

  logic [7:0] valid8;
  pick_t      pick;

  always_comb begin
    valid8                = '0;
    valid8[NUM_REQ-1:0]   = valid;
    pick                  = rr_pick(valid8, ptr, NUM_REQ);
  end

  assign found = pick.found;
  assign idx   = pick.idx;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ byte requesters.
// Define UART_ARB_TAG_EN to prefix each change of sender with a tag byte.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int BUSY_TMO = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [2:0]           grant_id,
  output logic                 launch_err,
  output logic [15:0]          byte_cnt
);

  localparam int               TMO_W    = $clog2(BUSY_TMO + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUSY_TMO - 1);
  localparam logic [2:0]       LAST_ID  = 3'(NUM_REQ - 1);

  arb_state_e         state, state_d;
  logic [2:0]         rr_ptr, rr_ptr_d;
  logic [TMO_W-1:0]   tmo_cnt, tmo_cnt_d;
  logic               tx_start_d;
  logic [7:0]         tx_data_d;
  logic [NUM_REQ-1:0] req_ready_d;
  logic [2:0]         grant_id_d;
  logic               launch_err_d;
  logic [15:0]        byte_cnt_d;

  logic               pick_found;
  logic [2:0]         pick_idx;
  logic [7:0]         data_arr [8];
  logic               do_data;
  logic [2:0]         data_idx;
  logic [7:0]         ready8;

`ifdef UART_ARB_TAG_EN
  logic [2:0]         lock_id, lock_id_d;
  logic [2:0]         last_id, last_id_d;
  logic               tag_pending, tag_pending_d;
  logic               have_sent, have_sent_d;
`endif

  uart_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Padded to 8 entries so a 3-bit index always selects in range.
  for (genvar g = 0; g < 8; g++) begin : g_data
    if (g < NUM_REQ) begin : g_used
      assign data_arr[g] = req_data[8*g +: 8];
    end else begin : g_pad
      assign data_arr[g] = '0;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d      = state;
    rr_ptr_d     = rr_ptr;
    tmo_cnt_d    = '0;
    tx_start_d   = 1'b0;
    tx_data_d    = tx_data;
    req_ready_d  = '0;
    grant_id_d   = grant_id;
    launch_err_d = launch_err;
    byte_cnt_d   = byte_cnt;
    do_data      = 1'b0;
    data_idx     = pick_idx;
    ready8       = '0;
`ifdef UART_ARB_TAG_EN
    lock_id_d     = lock_id;
    last_id_d     = last_id;
    tag_pending_d = tag_pending;
    have_sent_d   = have_sent;
`endif

    case (state)
      IDLE: begin
        if (!tx_busy) begin
`ifdef UART_ARB_TAG_EN
          if (tag_pending) begin
            do_data       = 1'b1;
            data_idx      = lock_id;
            tag_pending_d = 1'b0;
          end else if (pick_found) begin
            if (!have_sent || pick_idx != last_id) begin
              tx_start_d    = 1'b1;
              tx_data_d     = {TAG_NIBBLE, 1'b0, pick_idx};
              lock_id_d     = pick_idx;
              tag_pending_d = 1'b1;
              state_d       = TAG_LAUNCH;
            end else begin
              do_data = 1'b1;
            end
          end
`else
          do_data = pick_found;
`endif
        end
      end
      LAUNCH: state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (tmo_cnt == TMO_LAST) begin
          launch_err_d = 1'b1;
          state_d      = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt + 1'b1;
        end
      end
      WAIT_DONE: if (!tx_busy) state_d = IDLE;
`ifdef UART_ARB_TAG_EN
      TAG_LAUNCH: state_d = TAG_BUSY;
      TAG_BUSY: begin
        if (tx_busy) begin
          state_d = TAG_DONE;
        end else if (tmo_cnt == TMO_LAST) begin
          launch_err_d  = 1'b1;
          tag_pending_d = 1'b0;
          state_d       = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt + 1'b1;
        end
      end
      TAG_DONE: if (!tx_busy) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase

    if (do_data) begin
      ready8      = 8'd1 << data_idx;
      tx_start_d  = 1'b1;
      tx_data_d   = data_arr[data_idx];
      req_ready_d = ready8[NUM_REQ-1:0];
      grant_id_d  = data_idx;
      rr_ptr_d    = (data_idx == LAST_ID) ? 3'd0 : data_idx + 3'd1;
      byte_cnt_d  = byte_cnt + 16'd1;
      state_d     = LAUNCH;
`ifdef UART_ARB_TAG_EN
      last_id_d   = data_idx;
      have_sent_d = 1'b1;
`endif
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      tmo_cnt    <= '0;
      tx_start   <= 1'b0;
      tx_data    <= '0;
      req_ready  <= '0;
      grant_id   <= '0;
      launch_err <= 1'b0;
      byte_cnt   <= '0;
`ifdef UART_ARB_TAG_EN
      lock_id     <= '0;
      last_id     <= '0;
      tag_pending <= 1'b0;
      have_sent   <= 1'b0;
`endif
    end else begin
      state      <= state_d;
      rr_ptr     <= rr_ptr_d;
      tmo_cnt    <= tmo_cnt_d;
      tx_start   <= tx_start_d;
      tx_data    <= tx_data_d;
      req_ready  <= req_ready_d;
      grant_id   <= grant_id_d;
      launch_err <= launch_err_d;
      byte_cnt   <= byte_cnt_d;
`ifdef UART_ARB_TAG_EN
      lock_id     <= lock_id_d;
      last_id     <= last_id_d;
      tag_pending <= tag_pending_d;
      have_sent   <= have_sent_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural uart_tx and line receiver.
// Runs the tag-byte scenario instead of the data-only scenarios under UART_ARB_TAG_EN.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy = 1'b0;
  logic [2:0]  grant_id;
  logic        launch_err;
  logic [15:0] byte_cnt;

  logic        line = 1'b1;
  bit          uart_en = 1'b1;
  time         busy_fall_t = 0;
  logic [7:0]  rx_q [$];
  int          n_checks = 0;
  int          n_errors = 0;

`ifndef UART_ARB_TAG_EN
  logic [7:0]  exp_d [5] = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10};
  logic [2:0]  exp_g [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
`endif

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(4), .BUSY_TMO(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .grant_id   (grant_id),
    .launch_err (launch_err),
    .byte_cnt   (byte_cnt)
  );

  // uart_tx model: busy two cycles after tx_start, 2 clocks per bit, 8N1 LSB first.
  always begin
    logic [7:0] cap;
    @(negedge clk);
    if (uart_en && tx_start) begin
      cap = tx_data;
      @(negedge clk);
      tx_busy = 1'b1;
      line    = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        line = cap[i];
        repeat (2) @(negedge clk);
      end
      line = 1'b1;
      repeat (2) @(negedge clk);
      tx_busy     = 1'b0;
      busy_fall_t = $time;
    end
  end

  // Line receiver sampling mid-bit on rising edges.
  always begin
    logic [7:0] b;
    @(posedge clk);
    if (line == 1'b0) begin
      for (int i = 0; i < 8; i++) begin
        repeat (2) @(posedge clk);
        b[i] = line;
      end
      rx_q.push_back(b);
      repeat (2) @(posedge clk);
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic set_byte(input logic [1:0] idx, input logic [7:0] val);
    req_data[{idx, 3'b000} +: 8] = val;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tx_start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_ready(input logic [1:0] idx, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (req_ready[idx]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_rx(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (rx_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!tx_busy && !tx_start) break;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    req_valid = '0;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    rx_q.delete();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    bit  ok;
    time t_start;

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_launch_err", launch_err, 0);
    check("rst_byte_cnt", byte_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef UART_ARB_TAG_EN
    set_byte(2'd1, 8'h7E);
    req_valid = 4'b0010;
    wait_ready(2'd1, ok);
    check("tag_first_ready", ok, 1);
    check("tag_first_cnt", byte_cnt, 1);
    wait_ready(2'd1, ok);
    check("tag_second_ready", ok, 1);
    set_byte(2'd2, 8'h01);
    req_valid = 4'b0100;
    wait_ready(2'd2, ok);
    check("tag_third_ready", ok, 1);
    req_valid = '0;
    wait_rx(5, ok);
    check("tag_rx_count", ok, 1);
    if (ok) begin
      check("tag_line0", rx_q[0], 8'hA1);
      check("tag_line1", rx_q[1], 8'h7E);
      check("tag_line2", rx_q[2], 8'h7E);
      check("tag_line3", rx_q[3], 8'hA2);
      check("tag_line4", rx_q[4], 8'h01);
    end
    check("tag_byte_cnt", byte_cnt, 3);
    check("tag_grant_id", grant_id, 2);
`else
    // Single requester: one-cycle latency, one-cycle accept pulse.
    set_byte(2'd0, 8'h55);
    req_valid = 4'b0001;
    @(negedge clk);
    check("single_start", tx_start, 1);
    check("single_data", tx_data, 8'h55);
    check("single_ready", req_ready, 4'b0001);
    check("single_grant", grant_id, 0);
    check("single_cnt", byte_cnt, 1);
    req_valid = '0;
    @(negedge clk);
    check("single_start_drop", tx_start, 0);
    check("single_ready_drop", req_ready, 0);
    wait_rx(1, ok);
    check("single_rx_done", ok, 1);
    if (ok) check("single_line", rx_q[0], 8'h55);

    // All requesters held valid: strict rotation.
    wait_idle();
    do_reset();
    set_byte(2'd0, 8'h10);
    set_byte(2'd1, 8'h21);
    set_byte(2'd2, 8'h32);
    set_byte(2'd3, 8'h43);
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      wait_start(ok);
      check($sformatf("rr_start%0d", k), ok, 1);
      check($sformatf("rr_data%0d", k), tx_data, exp_d[k]);
      check($sformatf("rr_grant%0d", k), grant_id, exp_g[k]);
      if (k == 4) req_valid = '0;
    end
    wait_rx(5, ok);
    check("rr_rx_done", ok, 1);
    if (ok) begin
      for (int k = 0; k < 5; k++) check($sformatf("rr_line%0d", k), rx_q[k], exp_d[k]);
    end
    check("rr_cnt", byte_cnt, 5);

    // tx_busy never rises: error after BUSY_TMO cycles in WAIT_BUSY, then back to IDLE.
    wait_idle();
    do_reset();
    uart_en = 1'b0;
    set_byte(2'd1, 8'hA5);
    req_valid = 4'b0010;
    @(negedge clk);
    check("tmo_start", tx_start, 1);
    req_valid = '0;
    repeat (4) @(negedge clk);
    check("tmo_err_early", launch_err, 0);
    @(negedge clk);
    check("tmo_err_set", launch_err, 1);
    set_byte(2'd2, 8'h5A);
    req_valid = 4'b0100;
    @(negedge clk);
    check("tmo_idle_relaunch", tx_start, 1);
    check("tmo_idle_data", tx_data, 8'h5A);
    req_valid = '0;
    repeat (10) @(negedge clk);
    check("tmo_err_sticky", launch_err, 1);

    // Reset while uart_tx busy: immediate clear, no launch until busy falls.
    do_reset();
    uart_en = 1'b1;
    check("rst_clears_err", launch_err, 0);
    set_byte(2'd2, 8'h3C);
    req_valid = 4'b0100;
    wait_start(ok);
    check("busyrst_start", ok, 1);
    check("busyrst_grant", grant_id, 2);
    req_valid = '0;
    for (int i = 0; i < 20 && !tx_busy; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("busyrst_grant_clr", grant_id, 0);
    check("busyrst_data_clr", tx_data, 0);
    check("busyrst_cnt_clr", byte_cnt, 0);
    check("busyrst_start_clr", tx_start, 0);
    @(negedge clk);
    rst_n = 1'b1;
    set_byte(2'd0, 8'h55);
    req_valid = 4'b0001;
    wait_start(ok);
    t_start = $time;
    check("busyrst_relaunch", ok, 1);
    check("busyrst_gap_cycles", 32'((t_start - busy_fall_t) / 10), 1);
    check("busyrst_data", tx_data, 8'h55);
    check("busyrst_cnt", byte_cnt, 1);
    req_valid = '0;

    // byte_cnt wraps from 0xFFFF to 0.
    wait_idle();
    force dut.byte_cnt = 16'hFFFF;
    #1;
    release dut.byte_cnt;
    set_byte(2'd3, 8'hC3);
    req_valid = 4'b1000;
    wait_start(ok);
    check("wrap_start", ok, 1);
    check("wrap_cnt", byte_cnt, 16'h0000);
    check("wrap_grant", grant_id, 3);
    check("wrap_data", tx_data, 8'hC3);
    req_valid = '0;
    wait_idle();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
